// File: rtl/sort_mem_resp_if.sv
// Request/response bundle between the sort datapath and its array memory responder.
interface sort_mem_resp_if #(
  parameter int DATAWIDTH = 32
);
  logic                 rd;
  logic                 wr;
  logic                 init;
  logic [DATAWIDTH-1:0] address;
  logic [DATAWIDTH-1:0] wdata;
  logic [DATAWIDTH-1:0] rdata;
  logic                 ack;
  logic                 err;
  logic                 busy;

  modport master (
    output rd, wr, init, address, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  rd, wr, init, address, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/sort_mem_resp.sv
// Word-addressed array memory for the sort datapath: latency-programmable reads,
// single-cycle writes, error signalling for bad requests and a self-timed zero-fill sweep.
module sort_mem_resp #(
  parameter int DATAWIDTH  = 32,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic               dp_clk,
  input  logic               dp_clr_n,
  sort_mem_resp_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RWAIT = 2'd1,
    S_ACK   = 2'd2,
    S_SWEEP = 2'd3
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [AW-1:0]        r_idx;
  logic [AW-1:0]        r_addr;
  logic [DATAWIDTH-1:0] r_rdata;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_busy;

  logic [DATAWIDTH-1:0] r_mem [DEPTH];

  logic                 w_in_range;
  logic [AW-1:0]        w_req_idx;
  logic                 w_mem_we;
  logic [AW-1:0]        w_mem_waddr;
  logic [DATAWIDTH-1:0] w_mem_wdata;

  // Range check uses every address bit, so aliased high addresses are rejected.
  assign w_in_range = ((bus.address >> AW) == '0);
  assign w_req_idx  = bus.address[AW-1:0];

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = w_req_idx;
    w_mem_wdata = bus.wdata;
    if (r_state == S_SWEEP) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_idx;
      w_mem_wdata = '0;
    end else if (r_state == S_IDLE && !bus.init && bus.wr && !bus.rd && w_in_range) begin
      w_mem_we = 1'b1;
    end
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge dp_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge dp_clk or negedge dp_clr_n) begin
    if (!dp_clr_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.init) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SWEEP;
          end else if (bus.rd && bus.wr) begin
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ACK;
          end else if (bus.wr) begin
            r_ack   <= 1'b1;
            r_err   <= !w_in_range;
            r_busy  <= 1'b1;
            r_state <= S_ACK;
          end else if (bus.rd) begin
            r_busy <= 1'b1;
            if (!w_in_range) begin
              r_rdata <= '0;
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_ACK;
            end else if (RD_LATENCY == 1) begin
              r_rdata <= r_mem[w_req_idx];
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end else begin
              r_addr  <= w_req_idx;
              r_cnt   <= CW'(RD_LATENCY - 1);
              r_state <= S_RWAIT;
            end
          end
        end
        S_RWAIT: begin
          // Leaving on the count of one lands ack exactly RD_LATENCY cycles after acceptance.
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_rdata <= r_mem[r_addr];
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_SWEEP: begin
          r_idx <= r_idx + AW'(1);
          if (r_idx == AW'(DEPTH - 1)) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_sort_mem_resp.sv
// Randomized self-checking bench for sort_mem_resp against an array/latency reference model.
module tb_sort_mem_resp;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int LAT = 3;

  logic dp_clk   = 1'b0;
  logic dp_clr_n = 1'b0;

  sort_mem_resp_if #(.DATAWIDTH(DW)) bus ();

  sort_mem_resp #(
    .DATAWIDTH (DW),
    .DEPTH     (DEP),
    .RD_LATENCY(LAT)
  ) u_dut (
    .dp_clk  (dp_clk),
    .dp_clr_n(dp_clr_n),
    .bus     (bus)
  );

  initial forever #5 dp_clk = ~dp_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_mem   [DEP];
  bit            model_known [DEP];
  logic [DW-1:0] model_rdata;
  bit            rdata_known;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request from an IDLE cycle's negedge through the following IDLE cycle.
  task automatic do_req(input logic r, input logic w, input logic [DW-1:0] a,
                        input logic [DW-1:0] d, input bit perturb);
    int  k;
    int  exp_lat;
    bit  exp_err;
    bit  in_rng;
    bit  conflict;
    conflict = r && w;
    in_rng   = (a < DEP);
    if (conflict)      begin exp_lat = 1; exp_err = 1'b1; end
    else if (w)        begin exp_lat = 1; exp_err = !in_rng; end
    else               begin exp_lat = in_rng ? LAT : 1; exp_err = !in_rng; end
    check("idle_busy", bus.busy, 0);
    bus.rd = r; bus.wr = w; bus.address = a; bus.wdata = d;
    @(posedge dp_clk);
    if (!conflict && w && in_rng) begin
      model_mem[a[3:0]]   = d;
      model_known[a[3:0]] = 1'b1;
    end
    for (k = 1; k <= 64; k++) begin
      @(negedge dp_clk);
      if (bus.ack) break;
      check("busy_wait", bus.busy, 1);
      if (perturb && k == 1) begin
        bus.address = $urandom;
        bus.wdata   = $urandom;
      end
    end
    check("ack_latency", k, exp_lat);
    check("err", bus.err, exp_err);
    check("busy_ack", bus.busy, 1);
    if (r && !w) begin
      if (in_rng) begin
        model_rdata = model_mem[a[3:0]];
        rdata_known = model_known[a[3:0]];
      end else begin
        model_rdata = '0;
        rdata_known = 1'b1;
      end
    end
    if (rdata_known) check("rdata", bus.rdata, model_rdata);
    $display("req rd=%0b wr=%0b addr=%0h wdata=%0h -> lat=%0d err=%0b rdata=%0h",
             r, w, a, d, k, bus.err, bus.rdata);
    bus.rd = 1'b0; bus.wr = 1'b0;
    @(negedge dp_clk);
    check("ack_pulse", bus.ack, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  // Returns at the negedge of the ack cycle; with hold_wr the write stays asserted.
  task automatic do_sweep(input bit hold_wr, input logic [DW-1:0] a, input logic [DW-1:0] d);
    int k;
    int nb;
    nb = 0;
    bus.init = 1'b1;
    if (hold_wr) begin bus.wr = 1'b1; bus.address = a; bus.wdata = d; end
    @(posedge dp_clk);
    for (k = 1; k <= 64; k++) begin
      @(negedge dp_clk);
      if (k == 1) bus.init = 1'b0;
      if (bus.busy) nb++;
      if (bus.ack) break;
    end
    check("sweep_latency", k, DEP + 1);
    check("sweep_busy_cycles", nb, DEP + 1);
    check("sweep_err", bus.err, 0);
    for (int i = 0; i < DEP; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b1;
    end
    $display("sweep hold_wr=%0b -> ack_cycle=%0d busy_cycles=%0d", hold_wr, k, nb);
    if (!hold_wr) begin
      @(negedge dp_clk);
      check("sweep_busy_idle", bus.busy, 0);
    end
  endtask

  initial begin
    logic [DW-1:0] prior [DEP];
    int            typ;
    logic [DW-1:0] a;
    for (int i = 0; i < DEP; i++) model_known[i] = 1'b0;
    model_rdata = '0;
    rdata_known = 1'b1;
    bus.rd = 1'b1; bus.wr = 1'b0; bus.init = 1'b0;
    bus.address = '0; bus.wdata = '0;

    // Reset held with a read pending: nothing may start.
    repeat (3) @(negedge dp_clk);
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdata", bus.rdata, 0);
    dp_clr_n = 1'b1;
    rdata_known = 1'b1;
    do_req(1'b1, 1'b0, 0, 0, 1'b0);

    do_sweep(1'b0, 0, 0);
    do_req(1'b1, 1'b0, 5, 0, 1'b0);
    do_sweep(1'b1, 5, 32'h1234_5678);
    @(negedge dp_clk);
    do_req(1'b0, 1'b1, 5, 32'h1234_5678, 1'b0);
    do_req(1'b1, 1'b0, 5, 0, 1'b0);

    do_req(1'b0, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b1, 1'b0, 3, 0, 1'b0);

    do_req(1'b0, 1'b1, 0, 32'hA5A5_0F0F, 1'b0);
    do_req(1'b0, 1'b1, DEP, 32'h5555_AAAA, 1'b0);
    do_req(1'b1, 1'b0, 0, 0, 1'b0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);

    do_req(1'b1, 1'b0, 2, 0, 1'b0);
    do_req(1'b1, 1'b1, 2, 32'hCAFE_F00D, 1'b0);
    do_req(1'b1, 1'b0, 2, 0, 1'b0);

    for (int t = 0; t < 250; t++) begin
      typ = $urandom_range(0, 9);
      case ($urandom_range(0, 9))
        0:       a = $urandom | 32'h0000_0100;
        1:       a = DEP;
        2:       a = DEP - 1;
        default: a = $urandom_range(0, DEP - 1);
      endcase
      if (typ == 0)     do_req(1'b1, 1'b1, a, $urandom, $urandom_range(0, 1) == 1);
      else if (typ < 5) do_req(1'b0, 1'b1, a, $urandom, $urandom_range(0, 1) == 1);
      else              do_req(1'b1, 1'b0, a, 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) @(negedge dp_clk);
    end

    // Reset arriving while the sweep is about to clear index 7.
    for (int i = 0; i < DEP; i++) begin
      prior[i] = $urandom;
      do_req(1'b0, 1'b1, i, prior[i], 1'b0);
    end
    bus.init = 1'b1;
    @(posedge dp_clk);
    @(negedge dp_clk);
    bus.init = 1'b0;
    repeat (7) @(posedge dp_clk);
    @(negedge dp_clk);
    check("sweep_mid_busy", bus.busy, 1);
    dp_clr_n = 1'b0;
    #1;
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    @(negedge dp_clk);
    dp_clr_n = 1'b1;
    model_rdata = '0;
    rdata_known = 1'b1;
    for (int i = 0; i < DEP; i++) model_mem[i] = (i < 7) ? '0 : prior[i];
    for (int i = 0; i < DEP; i++) do_req(1'b1, 1'b0, i, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
